// File: rtl/dig_err_pkg.sv
//------------------------------------------------------------------------------
// Module : dig_err_pkg
// Brief  : Shared constants and state type for the digit-error capture stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dig_err_pkg;

    localparam int NDIG_DEF  = 20;
    localparam int CNT_W_DEF = 16;
    localparam int IDX_W_DEF = $clog2(NDIG_DEF);

    typedef enum logic [0:0] {
        CLEAN   = 1'b0,
        LATCHED = 1'b1
    } dig_err_state_t;

endpackage : dig_err_pkg

`default_nettype wire

// File: rtl/dig_err_prio_enc.sv
//------------------------------------------------------------------------------
// Module : dig_err_prio_enc
// Brief  : Combinational lowest-set-bit encoder with an any-bit-set flag.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dig_err_prio_enc
    import dig_err_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int IDX_W = $clog2(NDIG)
) (
    input  logic [NDIG-1:0]  flags,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (flags[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : dig_err_prio_enc

`default_nettype wire

// File: rtl/dig_error_capture.sv
//------------------------------------------------------------------------------
// Module : dig_error_capture
// Brief  : Sticky capture of per-digit residue errors, first-index record,
//          error-event counter (built only with DIG_ERR_COUNT_EN) and irq.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dig_error_capture
    import dig_err_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDX_W = $clog2(NDIG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             err_valid,
    input  logic [NDIG-1:0]  err_flags,
    input  logic             clear,
    output logic [NDIG-1:0]  dig_error,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_valid,
    output logic [CNT_W-1:0] err_count,
    output logic             irq
);

    dig_err_state_t   r_state;
    dig_err_state_t   w_state_nxt;
    logic [IDX_W-1:0] w_low_idx;
    logic             w_any;
    logic             w_event;
    logic             w_load_first;
    logic             w_accum;
    logic             w_zero;

    logic [NDIG-1:0]  r_dig_error;
    logic [IDX_W-1:0] r_first_idx;
    logic             r_first_valid;
    logic             r_irq;

    dig_err_prio_enc #(
        .NDIG  (NDIG),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .flags (err_flags),
        .idx   (w_low_idx),
        .any   (w_any)
    );

    assign w_event = err_valid & w_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A clear coinciding with an event restarts capture from that event.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = w_event ? LATCHED : CLEAN;
        end else begin
            unique case (r_state)
                CLEAN:   w_state_nxt = w_event ? LATCHED : CLEAN;
                LATCHED: w_state_nxt = LATCHED;
                default: w_state_nxt = CLEAN;
            endcase
        end
    end

    always_comb begin
        w_load_first = w_event & (clear | (r_state == CLEAN));
        w_accum      = w_event & ~clear & (r_state == LATCHED);
        w_zero       = clear & ~w_event;
    end

    always_ff @(posedge clk) begin
        if (reset || w_zero) begin
            r_dig_error   <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
            r_irq         <= 1'b0;
        end else if (w_load_first) begin
            r_dig_error   <= err_flags;
            r_first_idx   <= w_low_idx;
            r_first_valid <= 1'b1;
            r_irq         <= 1'b1;
        end else if (w_accum) begin
            r_dig_error   <= r_dig_error | err_flags;
        end
    end

`ifdef DIG_ERR_COUNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (clear) begin
            r_err_count <= w_event ? CNT_W'(1) : '0;
        end else if (w_event && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign dig_error   = r_dig_error;
    assign first_idx   = r_first_idx;
    assign first_valid = r_first_valid;
    assign irq         = r_irq;

endmodule : dig_error_capture

`default_nettype wire

// File: tb/tb_dig_error_capture.sv
//------------------------------------------------------------------------------
// Module : tb_dig_error_capture
// Brief  : Self-checking bench: directed vector table, saturation sequence and
//          randomized traffic against a behavioural model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dig_error_capture;

    localparam int NDIG   = 20;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 5;
    localparam int SCNT_W = 3;
`ifdef DIG_ERR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, err_valid, clear;
    logic [NDIG-1:0]  err_flags;
    logic [NDIG-1:0]  dig_error, dig_error_s;
    logic [IDX_W-1:0] first_idx, first_idx_s;
    logic             first_valid, first_valid_s, irq, irq_s;
    logic [CNT_W-1:0] err_count;
    logic [SCNT_W-1:0] err_count_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [NDIG-1:0] m_dig;
    int              m_idx, m_cnt, m_cnt_s;
    bit              m_fv;

    always #5 clk = ~clk;

    dig_error_capture #(.NDIG(NDIG), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .err_valid(err_valid), .err_flags(err_flags),
        .clear(clear), .dig_error(dig_error), .first_idx(first_idx),
        .first_valid(first_valid), .err_count(err_count), .irq(irq)
    );

    // Narrow-counter instance on the same inputs, to reach saturation quickly
    dig_error_capture #(.NDIG(NDIG), .CNT_W(SCNT_W), .IDX_W(IDX_W)) dut_s (
        .clk(clk), .reset(reset), .err_valid(err_valid), .err_flags(err_flags),
        .clear(clear), .dig_error(dig_error_s), .first_idx(first_idx_s),
        .first_valid(first_valid_s), .err_count(err_count_s), .irq(irq_s)
    );

    typedef struct {
        bit              rst;
        bit              clr;
        bit              vld;
        logic [NDIG-1:0] flg;
        logic [NDIG-1:0] e_dig;
        int              e_idx;
        bit              e_fv;
        int              e_cnt;
        bit              e_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NDIG-1:0] f);
        for (int i = 0; i < NDIG; i++) if (f[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        bit ev;
        ev = err_valid && (err_flags != '0);
        if (reset) begin
            m_dig = '0; m_idx = 0; m_fv = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (clear) begin
                m_dig = '0; m_idx = 0; m_fv = 0; m_cnt = 0; m_cnt_s = 0;
            end
            if (ev) begin
                if (!m_fv) begin
                    m_dig = err_flags; m_idx = lowest(err_flags); m_fv = 1;
                end else begin
                    m_dig = m_dig | err_flags;
                end
                if (m_cnt   < (1 << CNT_W)  - 1) m_cnt++;
                if (m_cnt_s < (1 << SCNT_W) - 1) m_cnt_s++;
            end
        end
    endtask

    task automatic apply(input bit r, input bit c, input bit v, input logic [NDIG-1:0] f);
        reset = r; clear = c; err_valid = v; err_flags = f;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".dig"},   32'(dig_error),   32'(m_dig));
        chk({tag, ".idx"},   32'(first_idx),   32'(m_idx));
        chk({tag, ".fv"},    32'(first_valid), 32'(m_fv));
        chk({tag, ".irq"},   32'(irq),         32'(m_fv));
        chk({tag, ".cnt"},   32'(err_count),   CNT_ON ? 32'(m_cnt) : 32'd0);
        chk({tag, ".cnt_s"}, 32'(err_count_s), CNT_ON ? 32'(m_cnt_s) : 32'd0);
    endtask

    function automatic vec_t mk(bit r, bit c, bit v, logic [NDIG-1:0] f,
                                logic [NDIG-1:0] d, int ix, bit fv, int cn, bit iq);
        vec_t t;
        t.rst = r; t.clr = c; t.vld = v; t.flg = f;
        t.e_dig = d; t.e_idx = ix; t.e_fv = fv; t.e_cnt = cn; t.e_irq = iq;
        return t;
    endfunction

    initial begin
        logic [NDIG-1:0] f;
        vec_t            t;
        reset = 1'b1; clear = 1'b0; err_valid = 1'b0; err_flags = '0;

        vecs.push_back(mk(1, 0, 0, 20'h00000, 20'h00000,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 20'h00000, 20'h00000,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 20'h00410, 20'h00410,  4, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 20'h80001, 20'h80411,  4, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0, 20'hFFFFF, 20'h80411,  4, 1, 2, 1));
        vecs.push_back(mk(0, 0, 1, 20'h00000, 20'h80411,  4, 1, 2, 1));
        vecs.push_back(mk(0, 1, 1, 20'h00008, 20'h00008,  3, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 20'h00000, 20'h00000,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 20'h40000, 20'h40000, 18, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 20'hFFFFF, 20'h00000,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 20'h80000, 20'h80000, 19, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 20'hFFFFF, 20'h80000, 19, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 20'hFFFFF, 20'h00000,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 20'h00001, 20'h00001,  0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 20'h00002, 20'h00000,  0, 0, 0, 0));

        // Reset then 10 idle cycles
        apply(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, '0);
            chk("idle.dig", 32'(dig_error), 32'd0);
            chk("idle.irq", 32'(irq), 32'd0);
            chk("idle.cnt", 32'(err_count), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            apply(t.rst, t.clr, t.vld, t.flg);
            chk($sformatf("v%0d.dig", i), 32'(dig_error),   32'(t.e_dig));
            chk($sformatf("v%0d.idx", i), 32'(first_idx),   32'(t.e_idx));
            chk($sformatf("v%0d.fv", i),  32'(first_valid), 32'(t.e_fv));
            chk($sformatf("v%0d.irq", i), 32'(irq),         32'(t.e_irq));
            chk($sformatf("v%0d.cnt", i), 32'(err_count),   CNT_ON ? 32'(t.e_cnt) : 32'd0);
        end

        // Saturation of the narrow counter, then clear-with-event restart
        apply(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) apply(0, 0, 1, NDIG'(1 << (i % NDIG)));
        chk("sat.cnt_s", 32'(err_count_s), CNT_ON ? 32'd7 : 32'd0);
        chk("sat.cnt",   32'(err_count),   CNT_ON ? 32'd10 : 32'd0);
        chk("sat.dig",   32'(dig_error),   32'h003FF);
        apply(0, 0, 1, 20'h00100);
        chk("sat.hold_s", 32'(err_count_s), CNT_ON ? 32'd7 : 32'd0);
        apply(0, 1, 1, 20'h00100);
        chk("sat.clr_s", 32'(err_count_s), CNT_ON ? 32'd1 : 32'd0);
        chk("sat.clr_idx", 32'(first_idx), 32'd8);

        // Randomized traffic against the model
        apply(1, 0, 0, '0);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(3))
                0: f = '0;
                1: f = NDIG'(1 << $urandom_range(NDIG - 1));
                default: f = NDIG'($urandom & 32'h000F_FFFF);
            endcase
            apply($urandom_range(39) == 0, $urandom_range(9) == 0,
                  $urandom_range(3) != 0, f);
            chk_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dig_error_capture

`default_nettype wire
